// File: rtl/rv_decode_stage.sv
// RV32I/RV32E decode stage: valid/ready input, registered ID/EX outputs, load-use bubble, flush.
// Optional macro DECODE_ILLEGAL_EN builds illegal-instruction detection; otherwise out_illegal is 0.
module rv_decode_stage #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_instr,
  input  logic [XLEN-1:0]    in_pc,
  input  logic               flush,
  output logic [RADDR_W-1:0] rs1_addr,
  output logic [RADDR_W-1:0] rs2_addr,
  input  logic [XLEN-1:0]    rs1_data,
  input  logic [XLEN-1:0]    rs2_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_pc,
  output logic [XLEN-1:0]    out_rs1_data,
  output logic [XLEN-1:0]    out_rs2_data,
  output logic [XLEN-1:0]    out_imm,
  output logic [RADDR_W-1:0] out_rs1,
  output logic [RADDR_W-1:0] out_rs2,
  output logic [RADDR_W-1:0] out_rd,
  output logic [2:0]         out_funct3,
  output logic               out_funct7b5,
  output logic               out_is_load,
  output logic               out_is_store,
  output logic               out_is_branch,
  output logic               out_is_jal,
  output logic               out_is_jalr,
  output logic               out_is_lui,
  output logic               out_is_auipc,
  output logic               out_is_alu_reg,
  output logic               out_is_alu_imm,
  output logic               out_reg_we,
  output logic               out_illegal
);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_MISC   = 7'b0001111;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  logic [6:0]         opcode_s;
  logic [RADDR_W-1:0] rs1_idx_s, rs2_idx_s, rd_idx_s;
  logic               is_load_d, is_store_d, is_branch_d, is_jal_d, is_jalr_d;
  logic               is_lui_d, is_auipc_d, is_alu_reg_d, is_alu_imm_d;
  logic               known_opc_s, writes_rd_s, uses_rs1_s, uses_rs2_s;
  logic               illegal_d, reg_we_d;
  logic [31:0]        imm32_s;
  logic [XLEN-1:0]    imm_d;
  logic               advance_s, hazard_s, load_s, valid_d;

  logic               valid_q;
  logic [XLEN-1:0]    pc_q, rs1_data_q, rs2_data_q, imm_q;
  logic [RADDR_W-1:0] rs1_q, rs2_q, rd_q;
  logic [2:0]         funct3_q;
  logic               funct7b5_q, is_load_q, is_store_q, is_branch_q, is_jal_q, is_jalr_q;
  logic               is_lui_q, is_auipc_q, is_alu_reg_q, is_alu_imm_q, reg_we_q;

  assign opcode_s  = in_instr[6:0];
  assign rs1_idx_s = in_instr[15 +: RADDR_W];
  assign rs2_idx_s = in_instr[20 +: RADDR_W];
  assign rd_idx_s  = in_instr[7 +: RADDR_W];
  assign rs1_addr  = rs1_idx_s;
  assign rs2_addr  = rs2_idx_s;

  // Opcode class flags, register usage and 32-bit immediate selection
  always_comb begin
    is_load_d    = 1'b0;
    is_store_d   = 1'b0;
    is_branch_d  = 1'b0;
    is_jal_d     = 1'b0;
    is_jalr_d    = 1'b0;
    is_lui_d     = 1'b0;
    is_auipc_d   = 1'b0;
    is_alu_reg_d = 1'b0;
    is_alu_imm_d = 1'b0;
    known_opc_s  = 1'b1;
    imm32_s      = 32'd0;
    case (opcode_s)
      OPC_LOAD: begin
        is_load_d = 1'b1;
        imm32_s   = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      OPC_OPIMM: begin
        is_alu_imm_d = 1'b1;
        imm32_s      = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      OPC_JALR: begin
        is_jalr_d = 1'b1;
        imm32_s   = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      OPC_STORE: begin
        is_store_d = 1'b1;
        imm32_s    = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      end
      OPC_BRANCH: begin
        is_branch_d = 1'b1;
        imm32_s     = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
      end
      OPC_LUI: begin
        is_lui_d = 1'b1;
        imm32_s  = {in_instr[31:12], 12'd0};
      end
      OPC_AUIPC: begin
        is_auipc_d = 1'b1;
        imm32_s    = {in_instr[31:12], 12'd0};
      end
      OPC_JAL: begin
        is_jal_d = 1'b1;
        imm32_s  = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
      end
      OPC_OP:     is_alu_reg_d = 1'b1;
      OPC_MISC:   known_opc_s  = 1'b1;
      OPC_SYSTEM: known_opc_s  = 1'b1;
      default:    known_opc_s  = 1'b0;
    endcase
  end

  assign imm_d       = {{(XLEN-31){imm32_s[31]}}, imm32_s[30:0]};
  assign writes_rd_s = is_alu_reg_d | is_alu_imm_d | is_load_d | is_lui_d |
                       is_auipc_d | is_jal_d | is_jalr_d;
  assign uses_rs1_s  = is_alu_reg_d | is_alu_imm_d | is_load_d | is_store_d |
                       is_branch_d | is_jalr_d;
  assign uses_rs2_s  = is_alu_reg_d | is_store_d | is_branch_d;

`ifdef DECODE_ILLEGAL_EN
  localparam bit RV32E = (RADDR_W == 4);
  logic illegal_q;

  // Unknown opcode, non-32-bit encoding, or an x16..x31 reference on RV32E
  always_comb begin
    illegal_d = !known_opc_s || (in_instr[1:0] != 2'b11);
    if (RV32E) begin
      illegal_d = illegal_d || (uses_rs1_s && in_instr[19]) ||
                  (uses_rs2_s && in_instr[24]) || (writes_rd_s && in_instr[11]);
    end else begin
      illegal_d = illegal_d;
    end
  end

  // Illegal flag travels with the rest of the ID/EX payload
  always_ff @(posedge clk) begin
    if (rst) begin
      illegal_q <= 1'b0;
    end else if (load_s) begin
      illegal_q <= illegal_d;
    end
  end
  assign out_illegal = illegal_q;
`else
  assign illegal_d   = 1'b0;
  assign out_illegal = 1'b0;
`endif

  assign reg_we_d = writes_rd_s && (rd_idx_s != '0) && !illegal_d;

  // Handshake, load-use hazard and next valid
  always_comb begin
    advance_s = !valid_q || out_ready;
    hazard_s  = valid_q && is_load_q && (rd_q != '0) && in_valid &&
                ((uses_rs1_s && (rs1_idx_s == rd_q)) || (uses_rs2_s && (rs2_idx_s == rd_q)));
    load_s    = 1'b0;
    if (flush) begin
      valid_d = 1'b0;
    end else if (advance_s && hazard_s) begin
      valid_d = 1'b0;
    end else if (advance_s && in_valid) begin
      valid_d = 1'b1;
      load_s  = 1'b1;
    end else if (advance_s) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
    in_ready = flush || (advance_s && !hazard_s);
  end

  // ID/EX pipeline register; payload only changes when an instruction is accepted
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q      <= 1'b0;
      pc_q         <= '0;
      rs1_data_q   <= '0;
      rs2_data_q   <= '0;
      imm_q        <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      rd_q         <= '0;
      funct3_q     <= 3'd0;
      funct7b5_q   <= 1'b0;
      is_load_q    <= 1'b0;
      is_store_q   <= 1'b0;
      is_branch_q  <= 1'b0;
      is_jal_q     <= 1'b0;
      is_jalr_q    <= 1'b0;
      is_lui_q     <= 1'b0;
      is_auipc_q   <= 1'b0;
      is_alu_reg_q <= 1'b0;
      is_alu_imm_q <= 1'b0;
      reg_we_q     <= 1'b0;
    end else begin
      valid_q <= valid_d;
      if (load_s) begin
        pc_q         <= in_pc;
        rs1_data_q   <= rs1_data;
        rs2_data_q   <= rs2_data;
        imm_q        <= imm_d;
        rs1_q        <= rs1_idx_s;
        rs2_q        <= rs2_idx_s;
        rd_q         <= rd_idx_s;
        funct3_q     <= in_instr[14:12];
        funct7b5_q   <= in_instr[30];
        is_load_q    <= is_load_d;
        is_store_q   <= is_store_d;
        is_branch_q  <= is_branch_d;
        is_jal_q     <= is_jal_d;
        is_jalr_q    <= is_jalr_d;
        is_lui_q     <= is_lui_d;
        is_auipc_q   <= is_auipc_d;
        is_alu_reg_q <= is_alu_reg_d;
        is_alu_imm_q <= is_alu_imm_d;
        reg_we_q     <= reg_we_d;
      end
    end
  end

  assign out_valid      = valid_q;
  assign out_pc         = pc_q;
  assign out_rs1_data   = rs1_data_q;
  assign out_rs2_data   = rs2_data_q;
  assign out_imm        = imm_q;
  assign out_rs1        = rs1_q;
  assign out_rs2        = rs2_q;
  assign out_rd         = rd_q;
  assign out_funct3     = funct3_q;
  assign out_funct7b5   = funct7b5_q;
  assign out_is_load    = is_load_q;
  assign out_is_store   = is_store_q;
  assign out_is_branch  = is_branch_q;
  assign out_is_jal     = is_jal_q;
  assign out_is_jalr    = is_jalr_q;
  assign out_is_lui     = is_lui_q;
  assign out_is_auipc   = is_auipc_q;
  assign out_is_alu_reg = is_alu_reg_q;
  assign out_is_alu_imm = is_alu_imm_q;
  assign out_reg_we     = reg_we_q;

endmodule

// File: tb/tb_rv_decode_stage.sv
// Directed bench for rv_decode_stage: immediates, flags, load-use bubble, back-pressure, flush, reset.
module tb_rv_decode_stage;
  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, rs1_data, rs2_data;
  logic [4:0]  rs1_addr, rs2_addr, out_rs1, out_rs2, out_rd;
  logic [31:0] out_pc, out_rs1_data, out_rs2_data, out_imm;
  logic [2:0]  out_funct3;
  logic        out_funct7b5, out_is_load, out_is_store, out_is_branch, out_is_jal, out_is_jalr;
  logic        out_is_lui, out_is_auipc, out_is_alu_reg, out_is_alu_imm, out_reg_we, out_illegal;
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  // Register-file stand-in: data encodes the index read
  assign rs1_data = 32'h1000_0000 | {27'd0, rs1_addr};
  assign rs2_data = 32'h2000_0000 | {27'd0, rs2_addr};

  rv_decode_stage #(.XLEN(32), .RADDR_W(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_pc(in_pc), .flush(flush), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
    .out_imm(out_imm), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_funct3(out_funct3), .out_funct7b5(out_funct7b5), .out_is_load(out_is_load),
    .out_is_store(out_is_store), .out_is_branch(out_is_branch), .out_is_jal(out_is_jal),
    .out_is_jalr(out_is_jalr), .out_is_lui(out_is_lui), .out_is_auipc(out_is_auipc),
    .out_is_alu_reg(out_is_alu_reg), .out_is_alu_imm(out_is_alu_imm),
    .out_reg_we(out_reg_we), .out_illegal(out_illegal)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_instr = 32'd0; in_pc = 32'd0; flush = 1'b0; out_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    #1;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", out_valid); end
    n_vec++; if ({out_imm, out_pc, out_rd, out_reg_we} !== 70'd0) begin n_err++; $display("FAIL reset_payload got %h/%h/%h/%b want 0", out_imm, out_pc, out_rd, out_reg_we); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_immediates();
    in_valid = 1'b1; in_instr = 32'hFFF00093; in_pc = 32'h0000_0100;  // addi x1,x0,-1
    tick();
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL addi_valid got %b want 1", out_valid); end
    n_vec++; if (out_imm !== 32'hFFFFFFFF) begin n_err++; $display("FAIL addi_imm got %h want ffffffff", out_imm); end
    n_vec++; if ({out_rd, out_reg_we, out_is_alu_imm} !== {5'd1, 1'b1, 1'b1}) begin n_err++; $display("FAIL addi_ctrl got rd=%0d we=%b alui=%b want 1/1/1", out_rd, out_reg_we, out_is_alu_imm); end
    n_vec++; if ({out_pc, out_rs1_data} !== {32'h100, 32'h1000_0000}) begin n_err++; $display("FAIL addi_pc_data got %h/%h want 100/10000000", out_pc, out_rs1_data); end
    in_instr = 32'hFE20AE23;  // sw x2,-4(x1)
    tick();
    n_vec++; if (out_imm !== 32'hFFFFFFFC) begin n_err++; $display("FAIL sw_imm got %h want fffffffc", out_imm); end
    n_vec++; if ({out_is_store, out_reg_we, out_rs1, out_rs2} !== {1'b1, 1'b0, 5'd1, 5'd2}) begin n_err++; $display("FAIL sw_ctrl got st=%b we=%b rs1=%0d rs2=%0d want 1/0/1/2", out_is_store, out_reg_we, out_rs1, out_rs2); end
    n_vec++; if (out_rs2_data !== 32'h2000_0002) begin n_err++; $display("FAIL sw_rs2_data got %h want 20000002", out_rs2_data); end
    in_instr = 32'hFE000CE3;  // beq x0,x0,-8
    tick();
    n_vec++; if ({out_imm, out_is_branch} !== {32'hFFFFFFF8, 1'b1}) begin n_err++; $display("FAIL beq got imm=%h br=%b want fffffff8/1", out_imm, out_is_branch); end
    in_instr = 32'h123450B7;  // lui x1,0x12345
    tick();
    n_vec++; if ({out_imm, out_is_lui, out_reg_we} !== {32'h12345000, 1'b1, 1'b1}) begin n_err++; $display("FAIL lui got imm=%h lui=%b we=%b want 12345000/1/1", out_imm, out_is_lui, out_reg_we); end
    in_instr = 32'h008000EF;  // jal x1,8
    tick();
    n_vec++; if ({out_imm, out_is_jal, out_rd} !== {32'h8, 1'b1, 5'd1}) begin n_err++; $display("FAIL jal got imm=%h jal=%b rd=%0d want 8/1/1", out_imm, out_is_jal, out_rd); end
    in_instr = 32'h00000013;  // addi x0,x0,0
    tick();
    n_vec++; if (out_reg_we !== 1'b0) begin n_err++; $display("FAIL rd0_we got %b want 0", out_reg_we); end
    in_instr = 32'h00000000;
    tick();
`ifdef DECODE_ILLEGAL_EN
    n_vec++; if ({out_illegal, out_reg_we} !== 2'b10) begin n_err++; $display("FAIL illegal_zero got %b%b want 10", out_illegal, out_reg_we); end
`else
    n_vec++; if (out_illegal !== 1'b0) begin n_err++; $display("FAIL illegal_off got %b want 0", out_illegal); end
`endif
  endtask

  task automatic test_load_use();
    in_valid = 1'b1; in_instr = 32'h0000A283;  // lw x5,0(x1)
    tick();
    n_vec++; if ({out_valid, out_is_load, out_rd} !== {1'b1, 1'b1, 5'd5}) begin n_err++; $display("FAIL lw got v=%b ld=%b rd=%0d want 1/1/5", out_valid, out_is_load, out_rd); end
    in_instr = 32'h00528333;  // add x6,x5,x5
    #1;
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL hazard_ready got %b want 0", in_ready); end
    tick();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bubble_valid got %b want 0", out_valid); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL after_bubble_ready got %b want 1", in_ready); end
    tick();
    n_vec++; if ({out_valid, out_is_alu_reg, out_rs1, out_rs2, out_rd} !== {1'b1, 1'b1, 5'd5, 5'd5, 5'd6}) begin n_err++; $display("FAIL add got v=%b alur=%b rs1=%0d rs2=%0d rd=%0d want 1/1/5/5/6", out_valid, out_is_alu_reg, out_rs1, out_rs2, out_rd); end
    n_vec++; if (out_rs1_data !== 32'h1000_0005) begin n_err++; $display("FAIL add_rs1_data got %h want 10000005", out_rs1_data); end
    in_instr = 32'h0000A003;  // lw x0,0(x1)
    tick();
    in_instr = 32'h00000333;  // add x6,x0,x0
    #1;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rd0_no_hazard got %b want 1", in_ready); end
    tick();
    n_vec++; if ({out_valid, out_rd} !== {1'b1, 5'd6}) begin n_err++; $display("FAIL rd0_follow got v=%b rd=%0d want 1/6", out_valid, out_rd); end
  endtask

  task automatic test_back_pressure();
    in_valid = 1'b0;
    tick();
    in_valid = 1'b1; in_instr = 32'h00500193; out_ready = 1'b0;  // addi x3,x0,5
    tick();
    n_vec++; if ({out_valid, out_rd} !== {1'b1, 5'd3}) begin n_err++; $display("FAIL bp_first got v=%b rd=%0d want 1/3", out_valid, out_rd); end
    in_instr = 32'h00700213;  // addi x4,x0,7
    for (int i = 0; i < 3; i++) begin
      #1;
      n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready[%0d] got %b want 0", i, in_ready); end
      tick();
      n_vec++; if ({out_valid, out_rd, out_imm} !== {1'b1, 5'd3, 32'd5}) begin n_err++; $display("FAIL bp_hold[%0d] got v=%b rd=%0d imm=%h want 1/3/5", i, out_valid, out_rd, out_imm); end
    end
    out_ready = 1'b1;
    #1;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_ready got %b want 1", in_ready); end
    tick();
    n_vec++; if ({out_valid, out_rd, out_imm} !== {1'b1, 5'd4, 32'd7}) begin n_err++; $display("FAIL bp_next got v=%b rd=%0d imm=%h want 1/4/7", out_valid, out_rd, out_imm); end
    in_valid = 1'b0;
    tick();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_drain got %b want 0", out_valid); end
  endtask

  task automatic test_flush();
    in_valid = 1'b1; in_instr = 32'h00500193;
    tick();
    in_instr = 32'h00700213; flush = 1'b1; out_ready = 1'b0;
    #1;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL flush_ready got %b want 1", in_ready); end
    tick();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid got %b want 0", out_valid); end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    n_vec++; if ({out_valid, out_rd} !== {1'b0, 5'd3}) begin n_err++; $display("FAIL flush_dropped got v=%b rd=%0d want 0/3", out_valid, out_rd); end
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b1; in_instr = 32'h00500193;
    tick();
    rst = 1'b1; in_instr = 32'h00700213; flush = 1'b1;
    tick();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    n_vec++; if ({out_valid, out_rd, out_imm} !== {1'b0, 5'd0, 32'd0}) begin n_err++; $display("FAIL mid_reset got v=%b rd=%0d imm=%h want 0/0/0", out_valid, out_rd, out_imm); end
  endtask

  initial begin
    test_reset();
    test_immediates();
    test_load_use();
    test_back_pressure();
    test_flush();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
